// File: rtl/rf_write_arbiter.sv
// Register file write-port arbiter: picks one of NUM_REQ writers per cycle, registered outputs.
// Define RF_ARB_ROUND_ROBIN_EN for round-robin selection; default build is fixed priority (0 first).
module rf_write_arbiter #(
    parameter int unsigned NUM_REQ     = 4,
    parameter int unsigned ADDR_W      = 5,
    parameter int unsigned DATA_W      = 32,
    parameter bit          ZERO_REG_RO = 1'b1
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      stall,
    input  logic [NUM_REQ-1:0]        req,
    input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
    input  logic [NUM_REQ*DATA_W-1:0] req_data,
    output logic [NUM_REQ-1:0]        gnt,
    output logic                      wr_en,
    output logic [ADDR_W-1:0]         wr_addr,
    output logic [DATA_W-1:0]         wr_data,
    output logic                      busy
);

    localparam int unsigned PtrW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    typedef enum logic [1:0] {StIdle, StGrant, StStall} state_e;

    state_e              state_q, state_d;
    logic [NUM_REQ-1:0]  gnt_q, gnt_d;
    logic                wr_en_q, wr_en_d;
    logic [ADDR_W-1:0]   wr_addr_q, wr_addr_d;
    logic [DATA_W-1:0]   wr_data_q, wr_data_d;

    logic [NUM_REQ-1:0]  elig;
    logic [PtrW-1:0]     win;
    logic                found;
    logic [ADDR_W-1:0]   sel_addr;
    logic [DATA_W-1:0]   sel_data;

`ifdef RF_ARB_ROUND_ROBIN_EN
    logic [PtrW-1:0]     ptr_q, ptr_d;
`endif

    // Last cycle's grant masks its owner so a late req drop cannot cause a double write.
    assign elig = req & ~gnt_q;

    always_comb begin : select
        logic [PtrW-1:0] idx;
`ifdef RF_ARB_ROUND_ROBIN_EN
        logic [PtrW:0]   sum;
        sum      = '0;
`endif
        idx      = '0;
        win      = '0;
        found    = 1'b0;
        sel_addr = '0;
        sel_data = '0;
        for (int unsigned off = 0; off < NUM_REQ; off++) begin
`ifdef RF_ARB_ROUND_ROBIN_EN
            sum = {1'b0, ptr_q} + (PtrW+1)'(off);
            if (sum >= (PtrW+1)'(NUM_REQ)) begin
                sum = sum - (PtrW+1)'(NUM_REQ);
            end
            idx = sum[PtrW-1:0];
`else
            idx = PtrW'(off);
`endif
            if (!found && elig[idx]) begin
                found    = 1'b1;
                win      = idx;
                sel_addr = req_addr[idx*ADDR_W +: ADDR_W];
                sel_data = req_data[idx*DATA_W +: DATA_W];
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        gnt_d     = '0;
        wr_en_d   = 1'b0;
        wr_addr_d = wr_addr_q;
        wr_data_d = wr_data_q;
`ifdef RF_ARB_ROUND_ROBIN_EN
        ptr_d     = ptr_q;
`endif
        if (stall) begin
            state_d = StStall;
        end else if (found) begin
            state_d   = StGrant;
            gnt_d     = NUM_REQ'(1) << win;
            wr_addr_d = sel_addr;
            wr_data_d = sel_data;
            wr_en_d   = !(ZERO_REG_RO && (sel_addr == '0));
`ifdef RF_ARB_ROUND_ROBIN_EN
            ptr_d     = (win == PtrW'(NUM_REQ - 1)) ? '0 : win + 1'b1;
`endif
        end else begin
            state_d = StIdle;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= StIdle;
            gnt_q     <= '0;
            wr_en_q   <= 1'b0;
            wr_addr_q <= '0;
            wr_data_q <= '0;
`ifdef RF_ARB_ROUND_ROBIN_EN
            ptr_q     <= '0;
`endif
        end else begin
            state_q   <= state_d;
            gnt_q     <= gnt_d;
            wr_en_q   <= wr_en_d;
            wr_addr_q <= wr_addr_d;
            wr_data_q <= wr_data_d;
`ifdef RF_ARB_ROUND_ROBIN_EN
            ptr_q     <= ptr_d;
`endif
        end
    end

    assign gnt     = gnt_q;
    assign wr_en   = wr_en_q;
    assign wr_addr = wr_addr_q;
    assign wr_data = wr_data_q;
    assign busy    = (state_q != StIdle);

endmodule

// File: doc/rf_write_arbiter.md
Name: rf_write_arbiter

Overview:
- Shares the single write port of the flip-flop register file among NUM_REQ requesters, for example the ALU writeback, the load unit and the CSR path.
- Accepts req/addr/data from each requester and picks one per cycle.
- Drives the register file write-enable, address and data. Returns a one-cycle grant pulse to the winner.
- Sits between the pipeline writeback stage and the register file.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- ADDR_W, 5, register address width.
- DATA_W, 32, register data width.
- ZERO_REG_RO, 1, when 1 a write to address 0 is granted but wr_en is suppressed.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-high reset.
- stall  input  1  register file not accepting writes. Freezes arbitration.
- req  input  NUM_REQ  per-requester write request. Level; payload held stable while high.
- req_addr  input  NUM_REQ*ADDR_W  packed addresses; requester i occupies bits [i*ADDR_W +: ADDR_W].
- req_data  input  NUM_REQ*DATA_W  packed data, same packing.
- gnt  output  NUM_REQ  one-hot grant pulse, registered.
- wr_en  output  1  register file write enable, registered.
- wr_addr  output  ADDR_W  registered write address.
- wr_data  output  DATA_W  registered write data.
- busy  output  1  high while the FSM is not IDLE.

Behaviour:
- All outputs are registered.
- Reset (asynchronous, effective immediately):
  - gnt=0, wr_en=0, wr_addr=0, wr_data=0, busy=0.
  - state=IDLE, priority pointer ptr=0.
- Eligible set, evaluated each rising edge: E = req & ~mask.
  - mask = gnt as currently driven, i.e. the grant of the cycle just ending.
  - This prevents a double grant to a requester that drops req one cycle late.
  - A requester may re-raise req immediately. It is eligible again one cycle later.
- Winner selection: first set bit of E scanning upward from ptr, wrapping modulo NUM_REQ.
- FSM states IDLE, GRANT, STALL. Transitions at each edge:
  - stall=1 (any state) -> STALL. gnt=0, wr_en=0. ptr, wr_addr and wr_data hold.
  - stall=0 and E!=0 -> GRANT. For winner w:
    - gnt = one-hot(w).
    - wr_addr = req_addr[w], wr_data = req_data[w].
    - wr_en = 1, except wr_en = 0 when ZERO_REG_RO=1 and req_addr[w]=0.
    - ptr = (w+1) mod NUM_REQ.
  - stall=0 and E=0 -> IDLE. gnt=0, wr_en=0, ptr holds.
- busy=1 in GRANT and STALL.
- Latency: req sampled high at edge k gives gnt/wr_en high in the cycle after edge k. The register file commits at edge k+1.
- Throughput: one write per cycle; back-to-back grants to different requesters are allowed.
- Single requester holding req continuously: granted every other cycle, due to the mask.
- Stall asserted in the same cycle as a pending request: stall wins; the request waits with no loss.
- Reset mid-operation: the in-flight gnt/wr_en is cleared immediately. No write occurs at the next edge.
- Pointer wrap: after the winner NUM_REQ-1, ptr becomes 0.
- Requesters with req=0 are never granted. gnt is always one-hot or zero.

Optional Feature:
- Macro: RF_ARB_ROUND_ROBIN_EN.
- Defined: round-robin selection using ptr, as described above.
- Undefined: fixed priority, index 0 highest. ptr is not implemented and selection scans from bit 0. The mask rule and stall behaviour are unchanged.

Test Plan:
- Reset, then req=0001, addr0=3, data0=0xDEADBEEF -> next cycle gnt=0001, wr_en=1, wr_addr=3, wr_data=0xDEADBEEF. If req is held, the next grant comes 2 cycles later.
- Round-robin: req=1111 held, round-robin macro defined -> gnt sequence 0001, 0010, 0100, 1000, 0001. Each requester is masked for one cycle after its grant.
- Fixed priority, macro undefined: req=0110 held -> gnt alternates 0010, 0100, 0010. Requester 1 is masked in the cycle after its grant, so 2 wins.
- Stall: req=0100, stall=1 for 3 cycles -> gnt=0, wr_en=0, busy=1 throughout. Stall drop -> gnt=0100 the next cycle.
- Zero register: ZERO_REG_RO=1, req=0001, addr0=0 -> gnt=0001 and wr_en=0. With ZERO_REG_RO=0 -> wr_en=1.
- Asynchronous reset asserted mid-cycle while gnt=0010 -> gnt, wr_en and busy go to 0 before the next edge. After release with req=1000, the winner is 3 and ptr restarts from 0.
